cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Transmit side of the common data bus (CDB). Accepts results from `num_RS_units` functional units through per-source valid/ready ports and buffers them in small per-source FIFOs. Each cycle it grants one buffered result in round-robin order and drives it onto the single `CDB` broadcast consumed by reservation stations, the ROB and the register file. Sits between the functional-unit outputs and the CDB wiring in the out-of-order core.

## Interface
- `NUM_SRC`, default `num_RS_units` (4): number of functional-unit sources.
- `DEPTH`, default 2: entries per source FIFO; legal values are 1, 2 and 4.
- `clk` in 1: sole clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `flush` in 1: mispredict flush; discards all buffered results.
- `src_valid` in `NUM_SRC`: source i presents a result.
- `src_data` in `NUM_SRC`×16 (`lc3b_word`): result value per source.
- `src_tag` in `NUM_SRC`×3 (`lc3b_rob_addr`): destination ROB entry per source.
- `src_ready` out `NUM_SRC`: source i's FIFO can accept a result this cycle.
- `cdb_out` out 20 (`CDB` struct {valid, data[15:0], tag[2:0]}): bus broadcast.

## Operation
- Handshake: a result transfers on source i when `src_valid[i] && src_ready[i]`. The source holds data and tag stable until that transfer.
- `src_ready[i]` = (count_i < `DEPTH`). It depends only on the registered count, never on the same-cycle pop. A full FIFO stays not-ready even while it pops.
- Each FIFO is in-order with wrap-around read/write pointers. Count width is clog2(`DEPTH`)+1.
- Eligible set = sources with count_i > 0, plus bypass candidates (see Configuration).
- Round-robin arbitration:
  - Search starts at `rr_ptr` and proceeds upward modulo `NUM_SRC`. The first eligible source wins.
  - On a grant, `rr_ptr` ← winner+1 (mod `NUM_SRC`).
  - With no grant, `rr_ptr` holds.
- Output: `cdb_out` = {1, head data, head tag} of the winner. With no eligible source, `cdb_out` = 0.
- The winner's head pops at the end of the grant cycle. A push and a pop on the same FIFO in the same cycle leave the count unchanged.
- Flush:
  - Clears all counts and pointers at the edge.
  - Forces `cdb_out.valid`=0 during the flush cycle.
  - Drops any push accepted in that cycle.
  - `rr_ptr` is unchanged.
- Reset:
  - Empties all FIFOs and sets `rr_ptr`=0.
  - `cdb_out` reads 0 and `src_ready` reads all-ones once reset is released.
  - Reset overrides flush and any in-flight transfer.
- Data and tag are passed bit-exact. No arithmetic is done on the payload.

## Timing
- Baseline latency is 1 cycle. A result accepted at edge N is visible on `cdb_out` in cycle N+1 if it wins arbitration.
- `cdb_out` is combinational from FIFO heads and `rr_ptr`, with no input-to-output path. Under bypass the path from `src_*` to `cdb_out` is combinational.
- Throughput is one broadcast per cycle total. A persistently valid source is granted at least once every `NUM_SRC` cycles.
- While reset is asserted, `cdb_out`=0 and `src_ready`=0.

## Configuration
- `CDB_BYPASS_EN` defined:
  - A source with count_i==0 and `src_valid[i]`=1 is eligible in the same cycle.
  - If it wins, its input drives `cdb_out` directly with 0-cycle latency, and the result is consumed without being written to the FIFO.
  - Losing bypass candidates are pushed normally.
- `CDB_BYPASS_EN` undefined: only FIFO heads are eligible, and the minimum latency is always 1 cycle.

## Test plan
- **Single source, no contention.** After reset, pulse source 2 with data 0x1234 and tag 5 for one cycle -> next cycle `cdb_out`={1,0x1234,5}, then valid=0. With bypass, the broadcast appears in the same cycle.
- **Round-robin fairness.** Sources 0..3 valid every cycle with tags 0..3 -> the CDB tag sequence is 0,1,2,3,0,1,… and each source is granted exactly once per 4 cycles.
- **Backpressure.**
  - Setup: `DEPTH`=2. Source 1 is held valid while sources 0, 2 and 3 are continuously valid.
  - Response: `src_ready[1]` drops once count hits 2 and rises the cycle after source 1's pop.
  - Check: no result is lost or duplicated, confirmed by a scoreboard on tags.
- **Simultaneous push and pop at full.** Source 0 is full and granted while `src_valid[0]`=1 -> no transfer that cycle (`src_ready[0]`=0), and count drops to 1.
- **Flush.**
  - Setup: 3 results buffered across sources, with a new push in the flush cycle.
  - Response: `cdb_out.valid`=0 in the flush cycle; next cycle all FIFOs are empty, `src_ready`=all-ones, and `rr_ptr` is preserved.
- **Reset mid-operation.** Assert `reset` with every FIFO full -> during reset `cdb_out`=0 and `src_ready`=0. After release the FIFOs are empty, the first grant goes to the lowest valid index starting from 0, and the data is correct.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter_if
//  Description : Source handshake and CDB broadcast bundle for cdb_arbiter.
//                cdb_out layout is {valid, data[15:0], tag[2:0]}.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cdb_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC-1:0][15:0] src_data;
    logic [NUM_SRC-1:0][2:0]  src_tag;
    logic [NUM_SRC-1:0]       src_ready;
    logic [19:0]              cdb_out;

    modport master (
        output src_valid, src_data, src_tag,
        input  src_ready, cdb_out
    );

    modport slave (
        input  src_valid, src_data, src_tag,
        output src_ready, cdb_out
    );
endinterface
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Per-source FIFOs feeding a round-robin arbiter that drives
//                the single CDB broadcast. Optional same-cycle bypass of
//                empty FIFOs is enabled by defining CDB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         flush,
    cdb_arbiter_if.slave      bus
);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam int c_SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef logic [18:0] entry_t;   // {data, tag}

    entry_t             r_mem    [NUM_SRC][DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr [NUM_SRC];
    logic [c_PTR_W-1:0] r_wr_ptr [NUM_SRC];
    logic [c_CNT_W-1:0] r_count  [NUM_SRC];
    logic [c_SRC_W-1:0] r_rr_ptr;

    logic [NUM_SRC-1:0] w_ready;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_pop;
    logic               w_found;
    logic               w_grant;
    logic [c_SRC_W-1:0] w_winner;
    entry_t             w_payload;

    function automatic logic [c_PTR_W-1:0] f_next_ptr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        // Readiness looks only at the registered count, so a full FIFO stays
        // closed even in the cycle it pops.
        assign w_ready[g] = !reset && (r_count[g] < c_CNT_W'(DEPTH));
`ifdef CDB_BYPASS_EN
        assign w_cand[g] = (r_count[g] == '0) && bus.src_valid[g];
`else
        assign w_cand[g] = 1'b0;
`endif
        assign w_eligible[g] = !reset && ((r_count[g] != '0) || w_cand[g]);
        assign w_pop[g]  = w_grant && (w_winner == c_SRC_W'(g)) && (r_count[g] != '0);
        // A bypass winner is consumed straight onto the bus, never stored.
        assign w_push[g] = bus.src_valid[g] && w_ready[g]
                           && !(w_grant && (w_winner == c_SRC_W'(g)) && w_cand[g]);
    end

    always_comb begin
        int v_idx;
        v_idx    = 0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            v_idx = (int'(r_rr_ptr) + i) % NUM_SRC;
            if (!w_found && w_eligible[v_idx[c_SRC_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = v_idx[c_SRC_W-1:0];
            end
        end
    end

    always_comb begin
        w_payload = r_mem[w_winner][r_rd_ptr[w_winner]];
`ifdef CDB_BYPASS_EN
        if (r_count[w_winner] == '0) begin
            w_payload = {bus.src_data[w_winner], bus.src_tag[w_winner]};
        end
`endif
    end

    assign w_grant       = w_found && !flush;
    assign bus.cdb_out   = w_grant ? {1'b1, w_payload} : '0;
    assign bus.src_ready = w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_count[i]  <= '0;
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
            end
        end else if (flush) begin
            // Flush empties the FIFOs but keeps the fairness position.
            for (int i = 0; i < NUM_SRC; i++) begin
                r_count[i]  <= '0;
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_winner == c_SRC_W'(NUM_SRC - 1)) ? '0 : w_winner + c_SRC_W'(1);
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= f_next_ptr(r_wr_ptr[i]);
                if (w_pop[i])  r_rd_ptr[i] <= f_next_ptr(r_rd_ptr[i]);
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + c_CNT_W'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_count[i] <= r_count[i] - c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_push[i] && !reset && !flush) begin
                r_mem[i][r_wr_ptr[i]] <= {bus.src_data[i], bus.src_tag[i]};
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cdb_arbiter
//  Description : Directed vector table plus scoreboard sequences for
//                cdb_arbiter (NUM_SRC=4, DEPTH=2, bypass disabled).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic flush;

    cdb_arbiter_if #(.NUM_SRC(4)) bus ();

    cdb_arbiter #(.NUM_SRC(4), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  vld;
        logic        fl;
        logic [15:0] dbase;
        logic [2:0]  tbase;
        logic [19:0] exp_cdb;
        logic [3:0]  exp_rdy;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    logic [15:0] sb_q [4][$];
    logic [13:0] sb_seq [4];
    int          sb_rr;

    function automatic logic [19:0] cdb(input logic [15:0] d, input logic [2:0] t);
        return {1'b1, d, t};
    endfunction

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle with all sources tagged by index; expectations come from a
    // queue-per-source model with its own round-robin pointer.
    task automatic sb_cycle(input logic [3:0] vld);
        logic [3:0]  e_rdy;
        logic [19:0] e_cdb;
        int          w;
        bit          found;
        @(negedge clk);
        flush = 1'b0;
        bus.src_valid = vld;
        for (int i = 0; i < 4; i++) begin
            bus.src_data[i] = {2'(i), sb_seq[i]};
            bus.src_tag[i]  = 3'(i);
        end
        #1;
        found = 1'b0;
        w     = 0;
        for (int i = 0; i < 4; i++) e_rdy[i] = (sb_q[i].size() < 2);
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (sb_rr + k) % 4;
            if (!found && sb_q[j].size() > 0) begin
                found = 1'b1;
                w     = j;
            end
        end
        e_cdb = found ? {1'b1, sb_q[w][0], 3'(w)} : 20'h0;
        chk("sb_cdb", bus.cdb_out, e_cdb);
        chk("sb_ready", 20'(bus.src_ready), 20'(e_rdy));
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && e_rdy[i]) begin
                sb_q[i].push_back({2'(i), sb_seq[i]});
                sb_seq[i] = sb_seq[i] + 14'd1;
            end
        end
        if (found) begin
            void'(sb_q[w].pop_front());
            sb_rr = (w + 1) % 4;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'h4, 1'b0, 16'h1232, 3'd3, 20'h0,             4'hF};
        vecs[1]  = '{4'h0, 1'b0, 16'h0000, 3'd0, cdb(16'h1234, 3'd5), 4'hF};
        vecs[2]  = '{4'h0, 1'b0, 16'h0000, 3'd0, 20'h0,             4'hF};
        vecs[3]  = '{4'hF, 1'b0, 16'h0100, 3'd0, 20'h0,             4'hF};
        vecs[4]  = '{4'hF, 1'b0, 16'h0200, 3'd0, cdb(16'h0103, 3'd3), 4'hF};
        vecs[5]  = '{4'hF, 1'b0, 16'h0300, 3'd0, cdb(16'h0100, 3'd0), 4'h8};
        vecs[6]  = '{4'hF, 1'b0, 16'h0400, 3'd0, cdb(16'h0101, 3'd1), 4'h1};
        vecs[7]  = '{4'h0, 1'b0, 16'h0000, 3'd0, cdb(16'h0102, 3'd2), 4'h2};
        vecs[8]  = '{4'h2, 1'b1, 16'h0900, 3'd0, 20'h0,             4'h6};
        vecs[9]  = '{4'h0, 1'b0, 16'h0000, 3'd0, 20'h0,             4'hF};
        vecs[10] = '{4'h9, 1'b0, 16'h5550, 3'd4, 20'h0,             4'hF};
        vecs[11] = '{4'h0, 1'b0, 16'h0000, 3'd0, cdb(16'h5553, 3'd7), 4'hF};
        vecs[12] = '{4'h0, 1'b0, 16'h0000, 3'd0, cdb(16'h5550, 3'd4), 4'hF};
        vecs[13] = '{4'h0, 1'b0, 16'h0000, 3'd0, 20'h0,             4'hF};
        vecs[14] = '{4'h3, 1'b0, 16'h6000, 3'd0, 20'h0,             4'hF};
        vecs[15] = '{4'h3, 1'b0, 16'h6100, 3'd0, cdb(16'h6001, 3'd1), 4'hF};
        vecs[16] = '{4'h1, 1'b0, 16'h6200, 3'd0, cdb(16'h6000, 3'd0), 4'hE};
        vecs[17] = '{4'h1, 1'b0, 16'h6200, 3'd0, cdb(16'h6101, 3'd1), 4'hF};
        vecs[18] = '{4'h0, 1'b0, 16'h0000, 3'd0, cdb(16'h6100, 3'd0), 4'hE};
        vecs[19] = '{4'h0, 1'b0, 16'h0000, 3'd0, cdb(16'h6200, 3'd0), 4'hF};
        vecs[20] = '{4'h0, 1'b0, 16'h0000, 3'd0, 20'h0,             4'hF};

        reset = 1'b1;
        flush = 1'b0;
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.src_tag   = '0;

        @(negedge clk);
        #1;
        chk("reset_cdb", bus.cdb_out, 20'h0);
        chk("reset_ready", 20'(bus.src_ready), 20'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_cdb", bus.cdb_out, 20'h0);
        chk("post_reset_ready", 20'(bus.src_ready), 20'hF);

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            flush = vecs[v].fl;
            bus.src_valid = vecs[v].vld;
            for (int i = 0; i < 4; i++) begin
                bus.src_data[i] = vecs[v].dbase + 16'(i);
                bus.src_tag[i]  = vecs[v].tbase + 3'(i);
            end
            #1;
            chk($sformatf("vec%0d_cdb", v), bus.cdb_out, vecs[v].exp_cdb);
            chk($sformatf("vec%0d_ready", v), 20'(bus.src_ready), 20'(vecs[v].exp_rdy));
        end

        // Restart from a clean state for the scoreboard run.
        @(negedge clk);
        flush = 1'b0;
        bus.src_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_rr = 0;
        for (int i = 0; i < 4; i++) sb_seq[i] = 14'd0;

        repeat (40) sb_cycle(4'hF);
        repeat (12) sb_cycle(4'h0);
        repeat (6)  sb_cycle(4'hF);

        // Reset in the middle of heavy traffic.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_cdb0", bus.cdb_out, 20'h0);
        chk("midrst_ready0", 20'(bus.src_ready), 20'h0);
        @(negedge clk);
        #1;
        chk("midrst_cdb1", bus.cdb_out, 20'h0);
        chk("midrst_ready1", 20'(bus.src_ready), 20'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.src_valid = 4'hC;
        bus.src_data[2] = 16'h7772;
        bus.src_tag[2]  = 3'd2;
        bus.src_data[3] = 16'h7773;
        bus.src_tag[3]  = 3'd3;
        #1;
        chk("rel_cdb", bus.cdb_out, 20'h0);
        chk("rel_ready", 20'(bus.src_ready), 20'hF);
        @(negedge clk);
        bus.src_valid = '0;
        #1;
        chk("rel_grant0", bus.cdb_out, cdb(16'h7772, 3'd2));
        @(negedge clk);
        #1;
        chk("rel_grant1", bus.cdb_out, cdb(16'h7773, 3'd3));
        @(negedge clk);
        #1;
        chk("rel_idle", bus.cdb_out, 20'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
